// File: rtl/ma_sample_pacer_pkg.sv
// Shared types and constants for the moving-average sample pacer.
// Holds the pacer state encoding and the underrun counter helpers.
package ma_sample_pacer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pacer_state_e;

    localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == UNDERRUN_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/ma_sample_pacer_if.sv
// Sample path of the pacer: upstream valid/ready source plus filter sample port.
// master = the pacer (sinks samples, drives the filter); slave = its surroundings.
interface ma_sample_pacer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         s_valid;
    logic signed [DATA_WIDTH-1:0] s_data;
    logic                         s_ready;
    logic                         enable;
    logic                         data_refresh;
    logic signed [DATA_WIDTH-1:0] din;

    modport master (
        input  s_valid, s_data,
        output s_ready, enable, data_refresh, din
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, enable, data_refresh, din
    );
endinterface

// File: rtl/ma_sync_fifo.sv
// Parameterised synchronous FIFO with first-word-through head output.
// Overflowing pushes and underflowing pops are ignored; DEPTH must be a power of two.
module ma_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is not reset; the level counter alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      level <= level + LW'(1);
            else if (pop_ok && !push_ok) level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/ma_sample_pacer.sv
// Paces buffered samples into the moving-average filter at a programmable rate.
// A down-counting divider marks strobe slots; each slot pops one sample or records an underrun.
module ma_sample_pacer
    import ma_sample_pacer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ma_sample_pacer_if.master             bus,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic                          cfg_start,
    input  logic                          cfg_stop,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    underrun_cnt,
    output logic                          busy
);
    pacer_state_e                 state;
    pacer_state_e                 state_next;
    logic [DIV_WIDTH-1:0]         div_q;
    logic [DIV_WIDTH-1:0]         div_next;
    logic [DIV_WIDTH-1:0]         eff_div_m1;
    logic                         slot;
    logic                         pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [DATA_WIDTH-1:0]        fifo_head;
    logic                         refresh_q;
    logic signed [DATA_WIDTH-1:0] din_q;

    ma_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.s_valid),
        .wdata (bus.s_data),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // A divide of 0 behaves as 1, so the reload value never underflows.
    assign eff_div_m1 = (cfg_div == '0) ? '0 : cfg_div - DIV_WIDTH'(1);
    assign slot       = (state != IDLE) && (div_q == '0);
    assign pop        = slot && !fifo_empty;

    assign busy             = (state != IDLE);
    assign bus.enable       = busy;
    assign bus.s_ready      = !fifo_full;
    assign bus.data_refresh = refresh_q;
    assign bus.din          = din_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cfg_start && !cfg_stop) state_next = RUN;
            end
            RUN: begin
                if (cfg_stop) state_next = DRAIN;
            end
            DRAIN: begin
                // A pending stop or restart outranks finishing the drain.
                if (cfg_stop)                 state_next = DRAIN;
                else if (cfg_start)           state_next = RUN;
                else if (slot && fifo_empty)  state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        div_next = div_q;
        if (state_next == IDLE)  div_next = '0;
        else if (state == IDLE)  div_next = eff_div_m1;
        else if (div_q == '0)    div_next = eff_div_m1;
        else                     div_next = div_q - DIV_WIDTH'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_q        <= '0;
            refresh_q    <= 1'b0;
            din_q        <= '0;
            underrun_cnt <= '0;
        end else begin
            state     <= state_next;
            div_q     <= div_next;
            refresh_q <= pop;
            if (pop) din_q <= fifo_head;
            // Empty slots only count as underruns while actively running.
            if (slot && fifo_empty && state == RUN)
                underrun_cnt <= sat_inc(underrun_cnt);
        end
    end

endmodule

// File: tb/tb_ma_sample_pacer.sv
// Self-checking bench for ma_sample_pacer: vector table, directed corner sequences
// and randomized traffic against a queue-based slot-schedule reference model.
module tb_ma_sample_pacer;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int DIVW  = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DIVW-1:0] cfg_div;
    logic            cfg_start;
    logic            cfg_stop;
    logic [3:0]      fifo_level;
    logic [7:0]      underrun_cnt;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ma_sample_pacer_if #(.DATA_WIDTH(DW)) bus ();

    ma_sample_pacer #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (DIVW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.master),
        .cfg_div      (cfg_div),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt),
        .busy         (busy)
    );

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sample queue and a "cycles into the current period" counter.
    int q[$];
    bit m_active, m_drain, m_refresh;
    int m_phase, m_period, m_din, m_under;

    function automatic int eff_of(input logic [DIVW-1:0] d);
        return (d == '0) ? 1 : int'(d);
    endfunction

    task automatic model_reset();
        q.delete();
        m_active = 0; m_drain = 0; m_refresh = 0;
        m_phase = 0; m_period = 1; m_din = 0; m_under = 0;
    endtask

    task automatic model_edge(input bit v, input int data, input bit start,
                              input bit stop, input int period);
        bit push;
        bit empty;
        bit slot;
        push      = v && (q.size() < DEPTH);
        empty     = (q.size() == 0);
        slot      = 0;
        m_refresh = 0;
        if (!m_active) begin
            if (start && !stop) begin
                m_active = 1; m_drain = 0; m_phase = 0; m_period = period;
            end
        end else begin
            slot = (m_phase + 1 == m_period);
            if (slot) begin
                m_phase  = 0;
                m_period = period;
                if (!empty) begin
                    m_din     = q.pop_front();
                    m_refresh = 1;
                end else if (!m_drain) begin
                    m_under = (m_under < 255) ? m_under + 1 : 255;
                end
            end else begin
                m_phase++;
            end
            if (stop)                             m_drain  = 1;
            else if (start)                       m_drain  = 0;
            else if (m_drain && slot && empty)    m_active = 0;
        end
        if (push) q.push_back(data);
    endtask

    task automatic compare_model();
        check("data_refresh", bus.data_refresh, m_refresh);
        check("din", $signed(bus.din), m_din);
        check("fifo_level", fifo_level, q.size());
        check("s_ready", bus.s_ready, q.size() < DEPTH);
        check("enable", bus.enable, m_active);
        check("busy", busy, m_active);
        check("underrun_cnt", underrun_cnt, m_under);
    endtask

    // One clock: inputs are captured before the edge, outputs compared 1 ns after it.
    task automatic cycle();
        bit v, st, sp;
        int d, p;
        v  = bus.s_valid;
        d  = int'($signed(bus.s_data));
        st = cfg_start;
        sp = cfg_stop;
        p  = eff_of(cfg_div);
        @(posedge clk);
        model_edge(v, d, st, sp, p);
        #1;
        compare_model();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".data_refresh"}, bus.data_refresh, 0);
        check({tag, ".din"}, $signed(bus.din), 0);
        check({tag, ".fifo_level"}, fifo_level, 0);
        check({tag, ".s_ready"}, bus.s_ready, 1);
        check({tag, ".enable"}, bus.enable, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".underrun_cnt"}, underrun_cnt, 0);
    endtask

    task automatic do_reset();
        bus.s_valid = 0; bus.s_data = '0;
        cfg_start = 0; cfg_stop = 0; cfg_div = '0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_reset_values("reset");
        rst_n = 1;
    endtask

    task automatic wait_idle(input string tag, input int budget, output int pulses);
        pulses = 0;
        for (int i = 0; i < budget && busy; i++) begin
            cycle();
            if (bus.data_refresh) pulses++;
        end
        check({tag, ".idle_reached"}, busy, 0);
    endtask

    typedef struct {
        bit v; int data; bit start; bit stop; int div;
        bit e_ref; int e_din; int e_level; bit e_en; int e_under;
    } vec_t;

    vec_t tbl[20];

    initial begin
        logic signed [DW-1:0] vals[8];
        int pulses;
        int cnt;

        // Push 100, -5, 7 while idle, then pace them out with cfg_div=4, then stop.
        tbl[0]  = '{1, 100, 0, 0, 4,  0, 0,   1, 0, 0};
        tbl[1]  = '{1, -5,  0, 0, 4,  0, 0,   2, 0, 0};
        tbl[2]  = '{1, 7,   0, 0, 4,  0, 0,   3, 0, 0};
        tbl[3]  = '{0, 0,   1, 0, 4,  0, 0,   3, 1, 0};
        tbl[4]  = '{0, 0,   0, 0, 4,  0, 0,   3, 1, 0};
        tbl[5]  = '{0, 0,   0, 0, 4,  0, 0,   3, 1, 0};
        tbl[6]  = '{0, 0,   0, 0, 4,  0, 0,   3, 1, 0};
        tbl[7]  = '{0, 0,   0, 0, 4,  1, 100, 2, 1, 0};
        tbl[8]  = '{0, 0,   0, 0, 4,  0, 100, 2, 1, 0};
        tbl[9]  = '{0, 0,   0, 0, 4,  0, 100, 2, 1, 0};
        tbl[10] = '{0, 0,   0, 0, 4,  0, 100, 2, 1, 0};
        tbl[11] = '{0, 0,   0, 0, 4,  1, -5,  1, 1, 0};
        tbl[12] = '{0, 0,   0, 0, 4,  0, -5,  1, 1, 0};
        tbl[13] = '{0, 0,   0, 0, 4,  0, -5,  1, 1, 0};
        tbl[14] = '{0, 0,   0, 0, 4,  0, -5,  1, 1, 0};
        tbl[15] = '{0, 0,   0, 0, 4,  1, 7,   0, 1, 0};
        tbl[16] = '{0, 0,   0, 1, 4,  0, 7,   0, 1, 0};
        tbl[17] = '{0, 0,   0, 0, 4,  0, 7,   0, 1, 0};
        tbl[18] = '{0, 0,   0, 0, 4,  0, 7,   0, 1, 0};
        tbl[19] = '{0, 0,   0, 0, 4,  0, 7,   0, 0, 0};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.s_valid = tbl[i].v;
            bus.s_data  = DW'(tbl[i].data);
            cfg_start   = tbl[i].start;
            cfg_stop    = tbl[i].stop;
            cfg_div     = DIVW'(tbl[i].div);
            cycle();
            check($sformatf("vec%0d.refresh", i), bus.data_refresh, tbl[i].e_ref);
            check($sformatf("vec%0d.din", i), $signed(bus.din), tbl[i].e_din);
            check($sformatf("vec%0d.level", i), fifo_level, tbl[i].e_level);
            check($sformatf("vec%0d.enable", i), bus.enable, tbl[i].e_en);
            check($sformatf("vec%0d.underrun", i), underrun_cnt, tbl[i].e_under);
        end
        cfg_start = 0; cfg_stop = 0; bus.s_valid = 0;

        // cfg_div=0 behaves as 1: eight back-to-back strobes, stop lands on the last pop.
        cfg_div = '0;
        for (int i = 0; i < 8; i++) begin
            vals[i]     = DW'($urandom);
            bus.s_valid = 1;
            bus.s_data  = vals[i];
            cycle();
        end
        bus.s_valid = 0;
        check("div0.full_ready", bus.s_ready, 0);
        check("div0.full_level", fifo_level, 8);
        cfg_start = 1;
        cycle();
        cfg_start = 0;
        for (int i = 0; i < 8; i++) begin
            cfg_stop = (i == 7);
            cycle();
            check($sformatf("div0.refresh%0d", i), bus.data_refresh, 1);
            check($sformatf("div0.din%0d", i), $signed(bus.din), vals[i]);
        end
        cfg_stop = 0;
        check("div0.level_empty", fifo_level, 0);
        cycle();
        check("div0.idle", busy, 0);
        check("div0.no_underrun", underrun_cnt, 0);

        // Empty FIFO in RUN: two slots give two underruns, then saturation.
        cfg_div = 3;
        cfg_start = 1;
        cycle();
        cfg_start = 0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (bus.data_refresh) cnt++;
        end
        check("underrun.two", underrun_cnt, 2);
        check("underrun.no_refresh", cnt, 0);
        check("underrun.din_held", $signed(bus.din), vals[7]);
        repeat (900) cycle();
        check("underrun.saturated", underrun_cnt, 255);
        cfg_stop = 1;
        cycle();
        cfg_stop = 0;
        wait_idle("underrun", 10, pulses);
        check("underrun.drain_no_count", underrun_cnt, 255);

        // Full FIFO back-pressure: the 9th sample waits until a pop frees space.
        do_reset();
        bus.s_valid = 1;
        for (int i = 0; i < 9; i++) begin
            bus.s_data = DW'(100 + i);
            if (i < 8) cycle();
        end
        cycle();
        cycle();
        check("full.ready_low", bus.s_ready, 0);
        check("full.level", fifo_level, 8);
        cfg_div = 1;
        cfg_start = 1;
        cycle();
        cfg_start = 0;
        cycle();
        check("full.pop_refresh", bus.data_refresh, 1);
        check("full.pop_din", $signed(bus.din), 100);
        check("full.ready_after_pop", bus.s_ready, 1);
        check("full.level_after_pop", fifo_level, 7);
        cycle();
        check("full.ninth_accepted", fifo_level, 7);
        bus.s_valid = 0;
        cfg_stop = 1;
        cycle();
        cfg_stop = 0;
        wait_idle("full", 30, pulses);
        check("full.total_pulses", pulses + 3, 9);
        check("full.last_din", $signed(bus.din), 108);

        // Drain with two samples left at cfg_div=2.
        do_reset();
        bus.s_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            bus.s_data = DW'(10 * i);
            cycle();
        end
        bus.s_valid = 0;
        cfg_div = 2;
        cfg_start = 1;
        cycle();
        cfg_start = 0;
        cycle();
        cycle();
        check("drain.first_pop", $signed(bus.din), 10);
        check("drain.queued", fifo_level, 2);
        cfg_stop = 1;
        cycle();
        cfg_stop = 0;
        wait_idle("drain", 20, pulses);
        check("drain.pulses", pulses, 2);
        check("drain.last_din", $signed(bus.din), 30);
        check("drain.enable_low", bus.enable, 0);
        check("drain.underrun", underrun_cnt, 0);

        // Asynchronous reset in the middle of DRAIN.
        bus.s_valid = 1;
        for (int i = 1; i <= 2; i++) begin
            bus.s_data = DW'(i);
            cycle();
        end
        bus.s_valid = 0;
        cfg_start = 1;
        cycle();
        cfg_start = 0;
        cfg_stop = 1;
        cycle();
        cfg_stop = 0;
        cycle();
        check("midreset.busy_before", busy, 1);
        #2 rst_n = 0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        cycle();

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) cfg_div = DIVW'($urandom_range(0, 5));
            bus.s_valid = $urandom_range(0, 1) == 1;
            bus.s_data  = DW'($urandom);
            cfg_start   = $urandom_range(0, 39) == 0;
            cfg_stop    = $urandom_range(0, 59) == 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
